// File: rtl/uart_frame_sequencer.sv
// UART frame sequencer: slices a packet into bytes (MSB byte first) and shifts each out as a UART frame.
// Optional parity bit in each frame is compiled in with `define UART_SEQ_PARITY_EN.
module uart_frame_sequencer #(
    parameter int PACKET_SIZE  = 32,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [PACKET_SIZE-1:0]                      i_pkt_data,
    input  logic                                        i_pkt_valid,
    output logic                                        o_pkt_ready,
    output logic                                        o_tx_serial,
    output logic                                        o_busy,
    output logic                                        o_frame_start,
    output logic                                        o_pkt_done,
    output logic [$clog2(((PACKET_SIZE+7)/8)+1)-1:0]    o_byte_index
);

    localparam int NUM_BYTES = (PACKET_SIZE + 7) / 8;
    localparam int IW        = $clog2(NUM_BYTES + 1);
    localparam int PAD_W     = NUM_BYTES * 8;
    localparam int CW        = $clog2(CLKS_PER_BIT);
`ifdef UART_SEQ_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE  = CW'(1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BYTES - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PACKET_SIZE-1:0]  r_pkt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [CW-1:0]           r_clk_cnt;
    logic [3:0]              r_bit_cnt;
    logic [IW-1:0]           r_byte_index;
    logic                    w_bit_end;
    logic                    w_frame_end;
    logic [PAD_W-1:0]        w_padded;
    logic [31:0]             w_shamt;
    logic [7:0]              w_byte;
    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_tx_nxt;

    function automatic logic f_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign w_bit_end    = (r_state == S_SEND) && (r_clk_cnt == CLK_LAST);
    assign w_frame_end  = w_bit_end && (r_bit_cnt == BIT_LAST);
    assign o_byte_index = r_byte_index;

    // Left-align the packet so a short final byte lands in the MSBs with zero-filled LSBs.
    always_comb begin
        w_padded                           = '0;
        w_padded[PAD_W-1 -: PACKET_SIZE]   = r_pkt;
        w_shamt = 32'(PAD_W - 8) - (32'd8 * 32'(r_byte_index));
        w_byte  = 8'(w_padded >> w_shamt);
`ifdef UART_SEQ_PARITY_EN
        w_frame = {1'b1, f_parity(w_byte), w_byte, 1'b1};
`else
        w_frame = {1'b1, w_byte, 1'b1};
`endif
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = i_pkt_valid ? S_LOAD : S_IDLE;
            S_LOAD:  w_state_nxt = S_SEND;
            S_SEND: begin
                if (w_frame_end) begin
                    w_state_nxt = (r_byte_index < IDX_LAST) ? S_LOAD : S_DONE;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next serial bit: frame LSB on load, next shift bit at a bit boundary, idle low otherwise.
    always_comb begin
        w_tx_nxt = 1'b0;
        case (r_state)
            S_LOAD: w_tx_nxt = w_frame[0];
            S_SEND: begin
                if (w_frame_end) begin
                    w_tx_nxt = 1'b0;
                end else if (w_bit_end) begin
                    w_tx_nxt = r_shift[1];
                end else begin
                    w_tx_nxt = r_shift[0];
                end
            end
            default: w_tx_nxt = 1'b0;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pkt_ready   <= 1'b1;
            o_busy        <= 1'b0;
            o_frame_start <= 1'b0;
            o_pkt_done    <= 1'b0;
            o_tx_serial   <= 1'b0;
        end else begin
            o_pkt_ready   <= (w_state_nxt == S_IDLE);
            o_busy        <= (w_state_nxt != S_IDLE);
            o_frame_start <= (w_state_nxt == S_LOAD);
            o_pkt_done    <= (w_state_nxt == S_DONE);
            o_tx_serial   <= w_tx_nxt;
        end
    end

    // Packet copy, frame shifter, bit/clock counters and byte index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pkt        <= '0;
            r_shift      <= '0;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= 4'd0;
            r_byte_index <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_pkt_valid) begin
                        r_pkt        <= i_pkt_data;
                        r_byte_index <= '0;
                    end else begin
                        r_byte_index <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift   <= w_frame;
                    r_clk_cnt <= '0;
                    r_bit_cnt <= 4'd0;
                end
                S_SEND: begin
                    if (w_frame_end) begin
                        r_clk_cnt <= '0;
                        if (r_byte_index < IDX_LAST) begin
                            r_byte_index <= r_byte_index + IDX_ONE;
                        end else begin
                            r_byte_index <= r_byte_index;
                        end
                    end else if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shift   <= {1'b0, r_shift[FRAME_BITS-1:1]};
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CLK_ONE;
                    end
                end
                S_DONE: begin
                    r_byte_index <= '0;
                end
                default: begin
                    r_byte_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench for uart_frame_sequencer: 32-bit and 12-bit packets, held-valid and mid-frame reset.
module tb_uart_frame_sequencer;

    localparam int CPB = 4;
`ifdef UART_SEQ_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int F = 1 + FB * CPB;

    logic        clk = 1'b0;
    logic        rst_a, valid_a, ready_a, tx_a, busy_a, fs_a, done_a;
    logic [31:0] data_a;
    logic [2:0]  idx_a;
    logic        rst_b, valid_b, ready_b, tx_b, busy_b, fs_b, done_b;
    logic [11:0] data_b;
    logic [1:0]  idx_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int frames [4][11];

    always #5 clk = ~clk;

    uart_frame_sequencer #(.PACKET_SIZE(32), .CLKS_PER_BIT(CPB)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_pkt_data(data_a), .i_pkt_valid(valid_a),
        .o_pkt_ready(ready_a), .o_tx_serial(tx_a), .o_busy(busy_a),
        .o_frame_start(fs_a), .o_pkt_done(done_a), .o_byte_index(idx_a));

    uart_frame_sequencer #(.PACKET_SIZE(12), .CLKS_PER_BIT(CPB)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_pkt_data(data_b), .i_pkt_valid(valid_b),
        .o_pkt_ready(ready_b), .o_tx_serial(tx_b), .o_busy(busy_b),
        .o_frame_start(fs_b), .o_pkt_done(done_b), .o_byte_index(idx_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected-frame column for the j-th transmitted bit (the close bit follows data when parity is absent).
    function automatic int col(input int j);
`ifdef UART_SEQ_PARITY_EN
        return j;
`else
        return (j == 9) ? 10 : j;
`endif
    endfunction

    // Sends one packet from IDLE and checks every output in cycles 1 .. nb*F+2 against the timing formulas.
    task automatic run_packet(input int which, input logic [31:0] data, input int nb, input bit hold);
        logic o_fs, o_done, o_ready, o_busy, o_tx;
        int   o_idx;
        logic e_fs, e_done, e_ready, e_busy, e_tx;
        int   e_idx, k, off;
        if (which == 0) begin data_a = data; valid_a = 1'b1; end
        else begin data_b = data[11:0]; valid_b = 1'b1; end
        @(posedge clk);
        for (int c = 1; c <= nb * F + 2; c++) begin
            @(negedge clk);
            cyc = c;
            if (which == 0) begin
                valid_a = hold;
                data_a  = $urandom;
                o_fs = fs_a; o_done = done_a; o_ready = ready_a; o_busy = busy_a; o_tx = tx_a; o_idx = int'(idx_a);
            end else begin
                valid_b = 1'b0;
                data_b  = 12'($urandom);
                o_fs = fs_b; o_done = done_b; o_ready = ready_b; o_busy = busy_b; o_tx = tx_b; o_idx = int'(idx_b);
            end
            e_fs = 1'b0; e_done = 1'b0; e_tx = 1'b0; e_idx = 0;
            e_ready = (c == nb * F + 2);
            e_busy  = !e_ready;
            k   = (c - 1) / F;
            off = (c - 1) % F;
            if (k < nb) begin
                e_idx = k;
                if (off == 0) e_fs = 1'b1;
                else e_tx = frames[k][col((off - 1) / CPB)] != 0;
            end else if (c == nb * F + 1) begin
                e_done = 1'b1;
                e_idx  = nb - 1;
            end
            chk("frame_start", 32'(o_fs), 32'(e_fs));
            chk("pkt_done", 32'(o_done), 32'(e_done));
            chk("pkt_ready", 32'(o_ready), 32'(e_ready));
            chk("busy", 32'(o_busy), 32'(e_busy));
            chk("tx_serial", 32'(o_tx), 32'(e_tx));
            chk("byte_index", 32'(o_idx), 32'(e_idx));
        end
    endtask

    initial begin
        int dones;
        rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        data_a = 32'h0; data_b = 12'h0;
        repeat (2) @(negedge clk);
        chk("rst pkt_ready", 32'(ready_a), 32'd1);
        chk("rst tx_serial", 32'(tx_a), 32'd0);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst frame_start", 32'(fs_a), 32'd0);
        chk("rst pkt_done", 32'(done_a), 32'd0);
        chk("rst byte_index", 32'(idx_a), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // 0xA507_00FF, frames listed in transmit order (open, d0..d7, parity, close)
        frames[0] = '{1,1,0,1,0,0,1,0,1,0,1};
        frames[1] = '{1,1,1,1,0,0,0,0,0,1,1};
        frames[2] = '{1,0,0,0,0,0,0,0,0,0,1};
        frames[3] = '{1,1,1,1,1,1,1,1,1,0,1};
        run_packet(0, 32'hA507_00FF, 4, 1'b0);

        // 12-bit packet 0xABC -> bytes 0xAB, 0xC0
        frames[0] = '{1,1,1,0,1,0,1,0,1,1,1};
        frames[1] = '{1,0,0,0,0,0,0,1,1,0,1};
        run_packet(1, 32'h0000_0ABC, 2, 1'b0);

        // Valid held high with data changing every cycle after the accept edge
        frames[0] = '{1,1,0,1,0,0,1,0,1,0,1};
        frames[1] = '{1,1,1,1,0,0,0,0,0,1,1};
        frames[2] = '{1,0,0,0,0,0,0,0,0,0,1};
        frames[3] = '{1,1,1,1,1,1,1,1,1,0,1};
        run_packet(0, 32'hA507_00FF, 4, 1'b1);
        @(negedge clk);
        cyc = 4 * F + 3;
        chk("second accept frame_start", 32'(fs_a), 32'd1);
        chk("second accept busy", 32'(busy_a), 32'd1);
        valid_a = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);

        // Reset asserted in cycle 60, during frame 1
        data_a = 32'hA507_00FF; valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1; valid_a = 1'b0;
        repeat (59) begin @(negedge clk); cyc++; end
        chk("pre-reset busy", 32'(busy_a), 32'd1);
        chk("pre-reset byte_index", 32'(idx_a), 32'd1);
        #1 rst_a = 1'b1;
        #1;
        chk("async rst tx_serial", 32'(tx_a), 32'd0);
        chk("async rst busy", 32'(busy_a), 32'd0);
        chk("async rst pkt_ready", 32'(ready_a), 32'd1);
        chk("async rst byte_index", 32'(idx_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        chk("no pkt_done after reset", 32'(dones), 32'd0);
        run_packet(0, 32'hA507_00FF, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_sequencer.md
# uart_frame_sequencer

Transmit-side controller for the BPSK modem's UART path. Accepts one PACKET_SIZE-bit system packet through a valid/ready handshake and slices it into bytes, MSB byte first. It wraps each byte in the team's 11-bit UART frame and shifts the frames out serially at a fixed bit period. Sits between the packet source and the modulator's serial input, and signals packet completion so the source can present the next packet.

## Interface
- PACKET_SIZE, 32: packet width in bits; ≥1. NUM_BYTES = ceil(PACKET_SIZE/8).
- CLKS_PER_BIT, 16: clock cycles per serial bit; ≥2.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- pkt_data  in  PACKET_SIZE  packet; sampled only on the accept edge.
- pkt_valid  in  1  source has a packet.
- pkt_ready  out  1  high only in IDLE; accept = pkt_valid & pkt_ready at a rising edge.
- tx_serial  out  1  serial line; idle level 0.
- busy  out  1  high in every state except IDLE.
- frame_start  out  1  one-cycle pulse in each LOAD cycle.
- pkt_done  out  1  one-cycle pulse in DONE.
- byte_index  out  $clog2(NUM_BYTES+1)  index of the byte currently loaded or sent; 0 in IDLE.

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: pkt_ready=1. On accept, register pkt_data into an internal copy, set byte_index=0, go to LOAD.
- LOAD (1 cycle): select byte k = packet[PACKET_SIZE-1-8k -: 8]. If fewer than 8 bits remain, the remaining bits occupy the byte MSBs and the LSBs are zero-filled. Example: PACKET_SIZE=12, 0xABC gives bytes 0xAB, 0xC0. Build frame = {close=1, parity=^byte, byte, open=1}. Load the shift register, clear bit and clock counters, pulse frame_start, go to SEND.
- SEND: transmit the frame LSB first: open, byte[0]..byte[7], parity, close. Each bit is held for exactly CLKS_PER_BIT cycles.
- After the last bit period: if byte_index < NUM_BYTES-1, increment byte_index and go to LOAD. Otherwise go to DONE.
- DONE (1 cycle): pulse pkt_done, tx_serial=0, return to IDLE.
- Between frames, tx_serial is 0 during the LOAD cycle.
- pkt_valid and pkt_data are ignored outside IDLE. The internal copy is immune to pkt_data changes after the accept edge.
- pkt_valid high in the DONE cycle is not accepted; acceptance is possible from the following (IDLE) cycle.

## Timing
- Reset values: pkt_ready=1, tx_serial=0, busy=0, frame_start=0, pkt_done=0, byte_index=0, state=IDLE.
- Outputs are all registered; tx_serial is driven directly from a flop.
- Accept edge at cycle 0. Frame k's LOAD occurs in cycle 1 + k·F, where F = 1 + FRAME_BITS·CLKS_PER_BIT.
- Bit j of frame k occupies cycles 2 + k·F + j·CLKS_PER_BIT through 1 + k·F + (j+1)·CLKS_PER_BIT.
- DONE occurs in cycle 1 + NUM_BYTES·F. pkt_ready is high again in the next cycle.
- FRAME_BITS is 11 with parity compiled in (see Configuration).
- Reset asserted mid-operation: all outputs take their reset values immediately and asynchronously. The packet is discarded; no pkt_done is issued.
- Counter widths: clock counter $clog2(CLKS_PER_BIT), bit counter 4 bits. Counters never wrap within a frame.

## Configuration
- UART_SEQ_PARITY_EN defined: frame is 11 bits (open, 8 data, parity, close) as above.
- UART_SEQ_PARITY_EN undefined: parity bit omitted. Frame is 10 bits (open, 8 data, close), FRAME_BITS=10, and all timing formulas use 10.

## Test plan
All scenarios use PACKET_SIZE=32, CLKS_PER_BIT=4, parity enabled, unless stated otherwise.
- Send 0xA507_00FF:
  - frame_start pulses in cycles 1, 46, 91, 136; pkt_done pulses in cycle 181; pkt_ready is high in cycle 182.
  - tx_serial bit sequence: 1,1,0,1,0,0,1,0,1,0,1 for 0xA5; 1,1,1,1,0,0,0,0,0,1,1 for 0x07; 1,0,0,0,0,0,0,0,0,0,1 for 0x00; 1,1,1,1,1,1,1,1,1,0,1 for 0xFF.
- PACKET_SIZE=12, send 0xABC: bytes 0xAB then 0xC0; pkt_done pulses in cycle 91.
- Hold pkt_valid high with changing pkt_data throughout: exactly one packet is accepted. Output matches the accept-edge data, and the next accept occurs at cycle 182.
- Assert rst in cycle 60, mid-frame 1: tx_serial=0 and busy=0 within the same cycle; no pkt_done is issued; a new packet is accepted after release.
- With UART_SEQ_PARITY_EN undefined, send 0xA507_00FF: frames are 10 bits; pkt_done pulses in cycle 165; the 0xFF frame is 1,1,1,1,1,1,1,1,1,1.
